// File: rtl/pi_pkg.sv
// -----------------------------------------------------------------------------
// pi_pkg
// Shared definitions for the PI loop sequencer slice:
//   - pi_state_e          : sequencer state encoding
//   - PI_PIPE_LATENCY_DEF : default latency of the PI arithmetic pipeline
//   - PI_INTEGRAL_LIMIT_BITS_DEF : default clamp exponent for the integral
//   - clamp_upper / clamp_lower : saturation bounds for a given exponent B,
//                                 i.e. 2^B-1 and -2^B
// -----------------------------------------------------------------------------
package pi_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_SAMPLE = 2'd1,
        COMPUTE     = 2'd2,
        OUTPUT      = 2'd3
    } pi_state_e;

    localparam int PI_PIPE_LATENCY_DEF        = 5;
    localparam int PI_INTEGRAL_LIMIT_BITS_DEF = 24;

    // Largest value the stored integral may take: 2^bits - 1.
    function automatic logic signed [63:0] clamp_upper(input int bits);
        return (64'sd1 <<< bits) - 64'sd1;
    endfunction

    // Smallest value the stored integral may take: -2^bits.
    function automatic logic signed [63:0] clamp_lower(input int bits);
        return -(64'sd1 <<< bits);
    endfunction

endpackage

// File: rtl/pi_integral_clamp.sv
// -----------------------------------------------------------------------------
// pi_integral_clamp
// Combinational signed saturator for the integral term. Limits the input to
// [-2^LIMIT_BITS, 2^LIMIT_BITS-1]; values already inside pass unchanged.
// Ports:
//   value   in  WIDTH  signed integral from the PI pipeline
//   clamped out WIDTH  saturated integral
// -----------------------------------------------------------------------------
module pi_integral_clamp
    import pi_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int LIMIT_BITS = PI_INTEGRAL_LIMIT_BITS_DEF
) (
    input  logic signed [WIDTH-1:0] value,
    output logic signed [WIDTH-1:0] clamped
);

    localparam logic signed [63:0]      HI_64 = clamp_upper(LIMIT_BITS);
    localparam logic signed [63:0]      LO_64 = clamp_lower(LIMIT_BITS);
    localparam logic signed [WIDTH-1:0] HI    = HI_64[WIDTH-1:0];
    localparam logic signed [WIDTH-1:0] LO    = LO_64[WIDTH-1:0];

    // Saturate against the signed bounds.
    always_comb begin
        clamped = value;
        if (value > HI) begin
            clamped = HI;
        end else if (value < LO) begin
            clamped = LO;
        end else begin
            clamped = value;
        end
    end

endmodule

// File: rtl/pi_loop_sequencer.sv
// -----------------------------------------------------------------------------
// pi_loop_sequencer
// Runs one PI control-loop iteration per accepted ADC sample. The accepted
// sample, setpoint, gains and current integral are registered as stable
// operands for a free-running PI pipeline; after PIPE_LATENCY+1 edges the
// pipeline results are captured, the integral is stored and the controller
// output is offered to the DAC writer.
//
// Build option: define PI_INTEGRAL_CLAMP_EN to saturate the stored integral to
// [-2^INTEGRAL_LIMIT_BITS, 2^INTEGRAL_LIMIT_BITS-1]; otherwise it wraps at
// OUTPUT_WIDTH.
//
// Ports:
//   clk, rst_L               clock, asynchronous active-low reset
//   enable                   loop run enable
//   integral_clear           zero the integral (IDLE only)
//   setpoint, kp, ki         loop targets/gains, latched per iteration
//   sample_valid/_ready/_data  ADC handshake
//   pipe_*  (out)            operands to the PI pipeline
//   pipe_integral_result, pipe_pi_result (in)  pipeline results
//   dac_valid/_ready/_data   DAC handshake
//   integral_value           stored integral
//   loop_count               completed iterations (wraps)
//   busy                     high whenever not in IDLE
// -----------------------------------------------------------------------------
module pi_loop_sequencer
    import pi_pkg::*;
#(
    parameter int INPUT_WIDTH         = 18,
    parameter int OUTPUT_WIDTH        = 32,
    parameter int PIPE_LATENCY        = PI_PIPE_LATENCY_DEF,
    parameter int INTEGRAL_LIMIT_BITS = PI_INTEGRAL_LIMIT_BITS_DEF
) (
    input  logic                    clk,
    input  logic                    rst_L,
    input  logic                    enable,
    input  logic                    integral_clear,
    input  logic [INPUT_WIDTH-1:0]  setpoint,
    input  logic [OUTPUT_WIDTH-1:0] kp,
    input  logic [OUTPUT_WIDTH-1:0] ki,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    input  logic [INPUT_WIDTH-1:0]  sample_data,
    output logic [INPUT_WIDTH-1:0]  pipe_setpoint,
    output logic [INPUT_WIDTH-1:0]  pipe_actual,
    output logic [OUTPUT_WIDTH-1:0] pipe_kp,
    output logic [OUTPUT_WIDTH-1:0] pipe_ki,
    output logic [OUTPUT_WIDTH-1:0] pipe_integral_input,
    input  logic [OUTPUT_WIDTH-1:0] pipe_integral_result,
    input  logic [OUTPUT_WIDTH-1:0] pipe_pi_result,
    output logic                    dac_valid,
    input  logic                    dac_ready,
    output logic [OUTPUT_WIDTH-1:0] dac_data,
    output logic [OUTPUT_WIDTH-1:0] integral_value,
    output logic [31:0]             loop_count,
    output logic                    busy
);

    localparam int              CNT_W    = $clog2(PIPE_LATENCY + 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PIPE_LATENCY);

    // The clamp only makes sense when its range fits inside the integral word.
    if ((INTEGRAL_LIMIT_BITS < 1) || (INTEGRAL_LIMIT_BITS > OUTPUT_WIDTH - 2)) begin : g_limit_bits_check
        $error("INTEGRAL_LIMIT_BITS must lie in 1 .. OUTPUT_WIDTH-2");
    end

    pi_state_e               state_r;
    pi_state_e               state_nxt_s;
    logic [CNT_W-1:0]        cnt_r;
    logic                    accept_s;
    logic                    capture_s;
    logic                    xfer_s;
    logic [OUTPUT_WIDTH-1:0] integral_store_s;

    logic                    sample_ready_r;
    logic                    dac_valid_r;
    logic                    busy_r;
    logic [INPUT_WIDTH-1:0]  op_setpoint_r;
    logic [INPUT_WIDTH-1:0]  op_actual_r;
    logic [OUTPUT_WIDTH-1:0] op_kp_r;
    logic [OUTPUT_WIDTH-1:0] op_ki_r;
    logic [OUTPUT_WIDTH-1:0] op_integral_r;
    logic [OUTPUT_WIDTH-1:0] dac_data_r;
    logic [OUTPUT_WIDTH-1:0] integral_r;
    logic [31:0]             loop_count_r;

`ifdef PI_INTEGRAL_CLAMP_EN
    pi_integral_clamp #(
        .WIDTH      (OUTPUT_WIDTH),
        .LIMIT_BITS (INTEGRAL_LIMIT_BITS)
    ) u_integral_clamp (
        .value   (pipe_integral_result),
        .clamped (integral_store_s)
    );
`else
    assign integral_store_s = pipe_integral_result;
`endif

    // Next-state logic and the single-cycle event strobes.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        capture_s   = 1'b0;
        xfer_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (enable) begin
                    state_nxt_s = WAIT_SAMPLE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT_SAMPLE: begin
                if (sample_valid && sample_ready_r) begin
                    accept_s    = 1'b1;
                    state_nxt_s = COMPUTE;
                end else if (!enable) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT_SAMPLE;
                end
            end
            COMPUTE: begin
                // cnt_r holds the number of edges already seen since
                // acceptance, so this edge is number cnt_r+1.
                if (cnt_r == CNT_LAST) begin
                    capture_s   = 1'b1;
                    state_nxt_s = OUTPUT;
                end else begin
                    state_nxt_s = COMPUTE;
                end
            end
            OUTPUT: begin
                if (dac_valid_r && dac_ready) begin
                    xfer_s = 1'b1;
                    if (enable) begin
                        state_nxt_s = WAIT_SAMPLE;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = OUTPUT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Handshake/status flags registered from the next state, so they never
    // depend combinationally on sample_valid or dac_ready.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            sample_ready_r <= 1'b0;
            dac_valid_r    <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            sample_ready_r <= (state_nxt_s == WAIT_SAMPLE);
            dac_valid_r    <= (state_nxt_s == OUTPUT);
            busy_r         <= (state_nxt_s != IDLE);
        end
    end

    // Pipeline latency counter.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == COMPUTE) && !capture_s) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Operand registers; the integral is snapshotted at acceptance so every
    // pipe_* output stays constant until the next acceptance.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            op_setpoint_r <= {INPUT_WIDTH{1'b0}};
            op_actual_r   <= {INPUT_WIDTH{1'b0}};
            op_kp_r       <= {OUTPUT_WIDTH{1'b0}};
            op_ki_r       <= {OUTPUT_WIDTH{1'b0}};
            op_integral_r <= {OUTPUT_WIDTH{1'b0}};
        end else if (accept_s) begin
            op_setpoint_r <= setpoint;
            op_actual_r   <= sample_data;
            op_kp_r       <= kp;
            op_ki_r       <= ki;
            op_integral_r <= integral_r;
        end else begin
            op_setpoint_r <= op_setpoint_r;
            op_actual_r   <= op_actual_r;
            op_kp_r       <= op_kp_r;
            op_ki_r       <= op_ki_r;
            op_integral_r <= op_integral_r;
        end
    end

    // Controller output capture; held while the DAC writer stalls.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            dac_data_r <= {OUTPUT_WIDTH{1'b0}};
        end else if (capture_s) begin
            dac_data_r <= pipe_pi_result;
        end else begin
            dac_data_r <= dac_data_r;
        end
    end

    // Stored integral: updated on capture, cleared only while idle.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            integral_r <= {OUTPUT_WIDTH{1'b0}};
        end else if (capture_s) begin
            integral_r <= integral_store_s;
        end else if ((state_r == IDLE) && integral_clear) begin
            integral_r <= {OUTPUT_WIDTH{1'b0}};
        end else begin
            integral_r <= integral_r;
        end
    end

    // Completed-iteration counter, wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            loop_count_r <= 32'd0;
        end else if (xfer_s) begin
            loop_count_r <= loop_count_r + 32'd1;
        end else begin
            loop_count_r <= loop_count_r;
        end
    end

    assign sample_ready        = sample_ready_r;
    assign dac_valid           = dac_valid_r;
    assign busy                = busy_r;
    assign pipe_setpoint       = op_setpoint_r;
    assign pipe_actual         = op_actual_r;
    assign pipe_kp             = op_kp_r;
    assign pipe_ki             = op_ki_r;
    assign pipe_integral_input = op_integral_r;
    assign dac_data            = dac_data_r;
    assign integral_value      = integral_r;
    assign loop_count          = loop_count_r;

endmodule

// File: tb/tb_pi_loop_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pi_loop_sequencer
// Directed bench for pi_loop_sequencer together with a behavioural PI
// arithmetic pipeline:
//   integral_result = integral_input + (actual - setpoint)
//   pi_result       = kp*(actual - setpoint) + ki*integral_result
// delayed by 5 register stages. The sequencer is built with
// INTEGRAL_LIMIT_BITS=8 so the clamp case is reachable with small samples.
// -----------------------------------------------------------------------------
module tb_pi_loop_sequencer;

    localparam int IW = 18;
    localparam int OW = 32;
    localparam int PL = 5;

`ifdef PI_INTEGRAL_CLAMP_EN
    localparam logic [31:0] EXP_INT_400 = 32'd255;
`else
    localparam logic [31:0] EXP_INT_400 = 32'd400;
`endif

    logic          clk = 1'b0;
    logic          rst_L = 1'b1;
    logic          enable = 1'b0;
    logic          integral_clear = 1'b0;
    logic [IW-1:0] setpoint = '0;
    logic [OW-1:0] kp = '0;
    logic [OW-1:0] ki = '0;
    logic          sample_valid = 1'b0;
    logic          sample_ready;
    logic [IW-1:0] sample_data = '0;
    logic [IW-1:0] pipe_setpoint;
    logic [IW-1:0] pipe_actual;
    logic [OW-1:0] pipe_kp;
    logic [OW-1:0] pipe_ki;
    logic [OW-1:0] pipe_integral_input;
    logic [OW-1:0] pipe_integral_result;
    logic [OW-1:0] pipe_pi_result;
    logic          dac_valid;
    logic          dac_ready = 1'b0;
    logic [OW-1:0] dac_data;
    logic [OW-1:0] integral_value;
    logic [31:0]   loop_count;
    logic          busy;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    pi_loop_sequencer #(
        .INPUT_WIDTH         (IW),
        .OUTPUT_WIDTH        (OW),
        .PIPE_LATENCY        (PL),
        .INTEGRAL_LIMIT_BITS (8)
    ) dut (
        .clk                  (clk),
        .rst_L                (rst_L),
        .enable               (enable),
        .integral_clear       (integral_clear),
        .setpoint             (setpoint),
        .kp                   (kp),
        .ki                   (ki),
        .sample_valid         (sample_valid),
        .sample_ready         (sample_ready),
        .sample_data          (sample_data),
        .pipe_setpoint        (pipe_setpoint),
        .pipe_actual          (pipe_actual),
        .pipe_kp              (pipe_kp),
        .pipe_ki              (pipe_ki),
        .pipe_integral_input  (pipe_integral_input),
        .pipe_integral_result (pipe_integral_result),
        .pipe_pi_result       (pipe_pi_result),
        .dac_valid            (dac_valid),
        .dac_ready            (dac_ready),
        .dac_data             (dac_data),
        .integral_value       (integral_value),
        .loop_count           (loop_count),
        .busy                 (busy)
    );

    // Behavioural PI arithmetic pipeline.
    logic signed [OW-1:0] m_err;
    logic signed [OW-1:0] m_int;
    logic signed [OW-1:0] m_pi;
    logic signed [OW-1:0] m_int_pipe [0:PL-1];
    logic signed [OW-1:0] m_pi_pipe  [0:PL-1];

    always_comb begin
        m_err = {{(OW-IW){pipe_actual[IW-1]}}, pipe_actual}
              - {{(OW-IW){pipe_setpoint[IW-1]}}, pipe_setpoint};
        m_int = $signed(pipe_integral_input) + m_err;
        m_pi  = $signed(pipe_kp) * m_err + $signed(pipe_ki) * m_int;
    end

    always @(posedge clk) begin
        m_int_pipe[0] <= m_int;
        m_pi_pipe[0]  <= m_pi;
        for (int i = 1; i < PL; i++) begin
            m_int_pipe[i] <= m_int_pipe[i-1];
            m_pi_pipe[i]  <= m_pi_pipe[i-1];
        end
    end

    assign pipe_integral_result = m_int_pipe[PL-1];
    assign pipe_pi_result       = m_pi_pipe[PL-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one sample, wait (bounded) for ready, let the acceptance edge pass.
    task automatic accept(input string tag, input logic [IW-1:0] sample);
        int k;
        k = 0;
        sample_data  = sample;
        sample_valid = 1'b1;
        while (!sample_ready && k < 20) begin
            tick();
            k++;
        end
        check({tag, "_ready"}, {31'd0, sample_ready}, 32'd1);
        tick();
        sample_valid = 1'b0;
        check({tag, "_pipe_actual"}, {14'd0, pipe_actual}, {14'd0, sample});
    endtask

    // Count edges until dac_valid, then check result and stored integral.
    task automatic wait_result(input string tag, input int exp_lat,
                               input logic [31:0] exp_dac, input logic [31:0] exp_int);
        int k;
        k = 0;
        while (!dac_valid && k < 20) begin
            tick();
            k++;
        end
        check({tag, "_latency"}, k, exp_lat);
        check({tag, "_dac_data"}, dac_data, exp_dac);
        check({tag, "_integral"}, integral_value, exp_int);
    endtask

    // Complete the DAC transfer with a one-edge dac_ready pulse.
    task automatic transfer(input string tag, input logic [31:0] exp_loops, input logic exp_ready);
        dac_ready = 1'b1;
        tick();
        dac_ready = 1'b0;
        check({tag, "_dac_valid_low"}, {31'd0, dac_valid}, 32'd0);
        check({tag, "_loop_count"}, loop_count, exp_loops);
        check({tag, "_sample_ready"}, {31'd0, sample_ready}, {31'd0, exp_ready});
    endtask

    task automatic go_idle_and_clear(input string tag);
        enable = 1'b0;
        tick();
        check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        integral_clear = 1'b1;
        tick();
        integral_clear = 1'b0;
        check({tag, "_cleared"}, integral_value, 32'd0);
    endtask

    initial begin
        logic seen_valid;
        logic [31:0] held;

        // ---- Reset state ----
        #1 rst_L = 1'b0;
        #1;
        check("rst_sample_ready", {31'd0, sample_ready}, 32'd0);
        check("rst_dac_valid", {31'd0, dac_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_loop_count", loop_count, 32'd0);
        tick();
        tick();
        rst_L = 1'b1;
        tick();

        // ---- Proportional only: 100 -> 100, integral 100, 6-cycle latency ----
        kp = 32'd1; ki = 32'd0; setpoint = 18'd0; enable = 1'b1;
        accept("prop", 18'd100);
        check("prop_busy", {31'd0, busy}, 32'd1);
        check("prop_pipe_kp", pipe_kp, 32'd1);
        wait_result("prop", 6, 32'd100, 32'd100);
        transfer("prop", 32'd1, 1'b1);

        // ---- Clear in IDLE ----
        enable = 1'b0;
        tick();
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_integral_kept", integral_value, 32'd100);
        integral_clear = 1'b1;
        tick();
        integral_clear = 1'b0;
        check("idle_clear", integral_value, 32'd0);

        // ---- Reset mid-COMPUTE discards the iteration ----
        integral_clear = 1'b0;
        kp = 32'd1; ki = 32'd0; enable = 1'b1;
        accept("rstmid", 18'd50);
        tick();
        tick();
        rst_L = 1'b0;
        #1;
        check("rstmid_dac_valid", {31'd0, dac_valid}, 32'd0);
        check("rstmid_dac_data", dac_data, 32'd0);
        check("rstmid_loop_count", loop_count, 32'd0);
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        check("rstmid_pipe_actual", {14'd0, pipe_actual}, 32'd0);
        check("rstmid_pipe_kp", pipe_kp, 32'd0);
        #1 rst_L = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (dac_valid) seen_valid = 1'b1;
        end
        check("rstmid_no_dac_valid", {31'd0, seen_valid}, 32'd0);
        check("rstmid_integral", integral_value, 32'd0);

        // ---- Integral accumulation: 10,10,10 -> 10,20,30 ----
        kp = 32'd0; ki = 32'd1; setpoint = 18'd0;
        accept("acc1", 18'd10);
        wait_result("acc1", 6, 32'd10, 32'd10);
        transfer("acc1", 32'd1, 1'b1);
        accept("acc2", 18'd10);
        wait_result("acc2", 6, 32'd20, 32'd20);
        transfer("acc2", 32'd2, 1'b1);
        accept("acc3", 18'd10);
        wait_result("acc3", 6, 32'd30, 32'd30);
        transfer("acc3", 32'd3, 1'b1);

        // ---- Clamp: 200,200 -> integral 200 then 255 (clamped) / 400 ----
        go_idle_and_clear("clamp");
        enable = 1'b1;
        accept("clamp1", 18'd200);
        wait_result("clamp1", 6, 32'd200, 32'd200);
        transfer("clamp1", 32'd4, 1'b1);
        accept("clamp2", 18'd200);
        wait_result("clamp2", 6, 32'd400, EXP_INT_400);
        transfer("clamp2", 32'd5, 1'b1);

        // ---- Backpressure with a negative error: 3*(5-20) = -45 ----
        go_idle_and_clear("bp");
        enable = 1'b1;
        kp = 32'd3; ki = 32'd0; setpoint = 18'd20;
        accept("bp", 18'd5);
        wait_result("bp", 6, 32'hFFFF_FFD3, 32'hFFFF_FFF1);
        held = dac_data;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_dac_data_stable", dac_data, 32'hFFFF_FFD3);
            check("bp_sample_ready_low", {31'd0, sample_ready}, 32'd0);
            check("bp_dac_valid_high", {31'd0, dac_valid}, 32'd1);
        end
        check("bp_dac_data_vs_first", dac_data, held);
        transfer("bp", 32'd6, 1'b1);

        // ---- Enable drop and integral_clear during COMPUTE ----
        // integral -15, err 10: integral -5, output 10 + (-5) = 5
        kp = 32'd1; ki = 32'd1; setpoint = 18'd0;
        accept("endrop", 18'd10);
        enable = 1'b0;
        integral_clear = 1'b1;
        tick();
        integral_clear = 1'b0;
        check("endrop_clear_ignored", integral_value, 32'hFFFF_FFF1);
        check("endrop_busy", {31'd0, busy}, 32'd1);
        wait_result("endrop", 5, 32'd5, 32'hFFFF_FFFB);
        transfer("endrop", 32'd7, 1'b0);
        check("endrop_idle_busy", {31'd0, busy}, 32'd0);
        tick();
        tick();
        check("endrop_stays_idle", {31'd0, busy}, 32'd0);
        check("endrop_integral_kept", integral_value, 32'hFFFF_FFFB);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pi_loop_sequencer.md
# pi_loop_sequencer

Sequencer that runs one iteration of the PI control loop per accepted ADC sample. It accepts a sample over a valid/ready handshake, presents stable operands to the free-running PI arithmetic pipeline, waits the pipeline latency, then captures the result. It stores the updated integral with optional anti-windup clamping and offers the controller output to the DAC writer over a valid/ready handshake. It sits between the ADC reader and the DAC writer.

## Interface
- INPUT_WIDTH, 18: ADC sample / setpoint width (signed).
- OUTPUT_WIDTH, 32: gain, integral and result width (signed).
- PIPE_LATENCY, 5: clock edges from operands registered into the pipeline to its result output being updated.
- INTEGRAL_LIMIT_BITS, 24: clamp range of the stored integral, −2^B … 2^B−1.
- clk  in  1  system clock.
- rst_L  in  1  asynchronous, active-low reset.
- enable  in  1  loop run enable.
- integral_clear  in  1  zero the integral (honoured in IDLE only).
- setpoint  in  INPUT_WIDTH  target value, latched per iteration.
- kp, ki  in  OUTPUT_WIDTH each  gains, latched per iteration.
- sample_valid / sample_ready  in / out  1  ADC handshake.
- sample_data  in  INPUT_WIDTH  ADC measurement.
- pipe_setpoint, pipe_actual  out  INPUT_WIDTH  pipeline operands.
- pipe_kp, pipe_ki, pipe_integral_input  out  OUTPUT_WIDTH  pipeline operands.
- pipe_integral_result, pipe_pi_result  in  OUTPUT_WIDTH  pipeline results.
- dac_valid / dac_ready  out / in  1  DAC handshake.
- dac_data  out  OUTPUT_WIDTH  controller output.
- integral_value  out  OUTPUT_WIDTH  stored integral.
- loop_count  out  32  completed iterations, wraps at 2^32.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, WAIT_SAMPLE, COMPUTE, OUTPUT.
- **IDLE:**
  - When enable=1, go to WAIT_SAMPLE.
  - When integral_clear=1, set integral to 0. If both enable and integral_clear are high, do both on the same edge.
- **WAIT_SAMPLE:**
  - sample_ready=1 in this state only.
  - On the edge where sample_valid&&sample_ready, latch sample_data, setpoint, kp and ki into the operand registers, clear the counter, and go to COMPUTE.
  - If enable=0 and no sample is accepted, go to IDLE.
- **COMPUTE:**
  - Operand registers drive the pipe_* outputs. pipe_integral_input = stored integral.
  - All pipe_* outputs are held constant until the next acceptance.
  - The counter counts edges. On the (PIPE_LATENCY+1)-th edge after acceptance, capture pipe_pi_result into dac_data, store pipe_integral_result (clamped if configured) into the integral, and go to OUTPUT.
- **OUTPUT:**
  - dac_valid=1. dac_data is held stable while waiting.
  - On dac_valid&&dac_ready, increment loop_count, then go to WAIT_SAMPLE if enable=1, else IDLE.
- enable falling during COMPUTE or OUTPUT does not abort: the iteration completes, then the block goes to IDLE.
- integral_clear is ignored outside IDLE.
- Reset values: state IDLE, sample_ready 0, dac_valid 0, dac_data 0, integral 0, loop_count 0, busy 0, all pipe_* operands 0.
- Reset asserted mid-iteration discards the iteration: no DAC transfer occurs and the integral is not updated.

## Timing
- Acceptance at edge N → integral and dac_data update at edge N+PIPE_LATENCY+1. dac_valid is first high after that edge (6 cycles with default parameters).
- Minimum iteration period with dac_ready tied high is PIPE_LATENCY+3 cycles: accept, PIPE_LATENCY+1 compute edges, transfer.
- sample_ready and dac_valid are registered outputs, never combinational from inputs. There is no path from dac_ready to sample_ready within the same cycle.
- integral_value changes only on the capture edge or an IDLE clear.

## Configuration
- PI_INTEGRAL_CLAMP_EN defined:
  - The captured integral is saturated to [−2^INTEGRAL_LIMIT_BITS, 2^INTEGRAL_LIMIT_BITS−1] before storage.
  - The clamped value feeds the next iteration.
- Undefined: pipe_integral_result is stored unmodified. Overflow wraps at OUTPUT_WIDTH.

## Structure
- Shared package pi_pkg holds:
  - the state enum (IDLE, WAIT_SAMPLE, COMPUTE, OUTPUT);
  - the PIPE_LATENCY default;
  - the clamp bound helper constants.
- Sub-module pi_integral_clamp: combinational saturator, instantiated only under PI_INTEGRAL_CLAMP_EN.
- The bench instantiates this block together with the PI arithmetic pipeline.

## Test plan
- **Reset state:** assert rst_L=0 mid-COMPUTE → all outputs return to reset values immediately. The integral is still 0 after reset release, and no dac_valid appears.
- **Proportional only:** kp=1, ki=0, setpoint=0, sample 100 → dac_data=100 with dac_valid rising exactly 6 cycles after acceptance. integral_value=100.
- **Integral accumulation:** kp=0, ki=1, setpoint=0, samples 10,10,10 → dac_data 10, 20, 30. integral_value=30, loop_count=3.
- **Clamp, macro defined:** INTEGRAL_LIMIT_BITS=8, ki=1, kp=0, setpoint=0, samples 200, 200 → integral_value 200 then 255. Without the macro → 400.
- **Backpressure:** dac_ready held 0 for 10 cycles → dac_data stable and sample_ready=0 throughout. The transfer completes on the edge dac_ready=1, and sample_ready rises the next cycle.
- **Enable and clear:** drop enable during COMPUTE → one transfer completes, then IDLE with busy=0. Pulse integral_clear in IDLE → integral_value=0. Pulse it during COMPUTE → no effect.
